vita49_pack: RTL and testbench

- Transmit-side counterpart of vita49_unpack.
- Takes a raw 32-bit sample stream on AXI-Stream and wraps it into VITA-49 IF Data packets: header, stream ID, integer timestamp, 64-bit fractional timestamp, then a fixed-length payload.
- Sits between the sample source (DMA or DSP chain) and the transport/link layer.
- Passes the payload through with zero latency and needs no packet buffer.

---
 rtl/vita49_pack.sv | 199 +++++++++++++++++++
 tb/tb_vita49_pack.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_pack.sv
// vita49_pack: wraps a raw 32-bit AXI-Stream sample stream into VITA-49
// IF Data packets (header, stream ID, integer and fractional timestamps,
// then a fixed-length payload). The header words come from registers and
// the payload is passed straight through, so no packet buffer is needed.
module vita49_pack #(
  parameter logic [3:0] PKT_TYPE = 4'h1,
  parameter logic [1:0] TSI_TYPE = 2'b01,
  parameter logic [1:0] TSF_TYPE = 2'b01
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic        S_AXIS_TLAST,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  input  logic [31:0] ctrl,
  output logic [31:0] status,
  input  logic [31:0] streamID,
  input  logic [15:0] pkt_size,
  input  logic        trig,
  input  logic [31:0] timestamp_sec,
  input  logic [63:0] timestamp_fsec
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_HDR     = 3'd2,
    S_SID     = 3'd3,
    S_TSI     = 3'd4,
    S_TSFH    = 3'd5,
    S_TSFL    = 3'd6,
    S_PAYLOAD = 3'd7
  } state_t;

  state_t      state_q;
  logic [3:0]  pkt_cnt_q;
  logic [15:0] sent_q;
  logic [15:0] beat_q;
  logic [15:0] size_q;
  logic [31:0] sid_q;
  logic [31:0] sec_q;
  logic [63:0] fsec_q;
  logic        trig_q;
  logic [31:0] tdata_q;
  logic        tvalid_q;

  logic        rst;
  logic        passthru;
  logic        in_payload;
  logic        last_beat;
  logic        beat_xfer;
  logic        start_d;
  logic        trig_d;
  logic [15:0] size_eff_d;
  logic [31:0] hdr_word_d;
  logic        unused_ctrl;

  // Hard reset and the soft-reset control bit act identically.
  assign rst = ~AXIS_ARESETN | ctrl[1];

  // Upper control bits carry no function.
  assign unused_ctrl = ^ctrl[31:4];

  // Packet-start decision, header word assembly and payload beat tracking.
  always_comb begin
    size_eff_d = (pkt_size == 16'd0) ? 16'd1 : pkt_size;
    // Size field counts the five header words; it wraps for huge payloads.
    hdr_word_d = {PKT_TYPE, 2'b00, 2'b00, TSI_TYPE, TSF_TYPE, pkt_cnt_q,
                  size_eff_d + 16'd5};
    passthru   = (state_q == S_IDLE) && ctrl[2];
    in_payload = (state_q == S_PAYLOAD);
    last_beat  = in_payload && (beat_q == size_q - 16'd1);
    beat_xfer  = in_payload && S_AXIS_TVALID && M_AXIS_TREADY;
    // Once a trigger is seen it stays armed until enable drops, so later
    // packets start straight from IDLE without waiting in ARMED again.
    trig_d     = ctrl[0] && (trig_q || ((state_q == S_ARMED) && trig));
    start_d    = 1'b0;
    if (state_q == S_IDLE) begin
      start_d = ctrl[0] && !ctrl[2] && !(ctrl[3] && !trig_q) && S_AXIS_TVALID;
    end else if (state_q == S_ARMED) begin
      start_d = ctrl[0] && (trig || trig_q) && S_AXIS_TVALID;
    end
  end

  // Packet FSM: latches per-packet fields at start and steps header words.
  always_ff @(posedge AXIS_ACLK) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pkt_cnt_q <= 4'd0;
      sent_q    <= 16'd0;
      beat_q    <= 16'd0;
      size_q    <= 16'd0;
      sid_q     <= 32'd0;
      sec_q     <= 32'd0;
      fsec_q    <= 64'd0;
      trig_q    <= 1'b0;
      tdata_q   <= 32'd0;
      tvalid_q  <= 1'b0;
    end else begin
      trig_q <= trig_d;
      if (start_d) begin
        state_q  <= S_HDR;
        size_q   <= size_eff_d;
        sid_q    <= streamID;
        sec_q    <= timestamp_sec;
        fsec_q   <= timestamp_fsec;
        tdata_q  <= hdr_word_d;
        tvalid_q <= 1'b1;
        beat_q   <= 16'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ctrl[0] && !ctrl[2] && ctrl[3] && !trig_q) begin
              state_q <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (!ctrl[0]) begin
              state_q <= S_IDLE;
            end
          end
          S_HDR: begin
            if (M_AXIS_TREADY) begin
              state_q <= S_SID;
              tdata_q <= sid_q;
            end
          end
          S_SID: begin
            if (M_AXIS_TREADY) begin
              state_q <= S_TSI;
              tdata_q <= sec_q;
            end
          end
          S_TSI: begin
            if (M_AXIS_TREADY) begin
              state_q <= S_TSFH;
              tdata_q <= fsec_q[63:32];
            end
          end
          S_TSFH: begin
            if (M_AXIS_TREADY) begin
              state_q <= S_TSFL;
              tdata_q <= fsec_q[31:0];
            end
          end
          S_TSFL: begin
            if (M_AXIS_TREADY) begin
              state_q  <= S_PAYLOAD;
              tdata_q  <= 32'd0;
              tvalid_q <= 1'b0;
              beat_q   <= 16'd0;
            end
          end
          S_PAYLOAD: begin
            if (beat_xfer) begin
              if (last_beat) begin
                state_q   <= S_IDLE;
                pkt_cnt_q <= pkt_cnt_q + 4'd1;
                sent_q    <= sent_q + 16'd1;
                beat_q    <= 16'd0;
              end else begin
                beat_q <= beat_q + 16'd1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Output mux: registered header words, or a direct wire to the source
  // during payload and passthrough.
  always_comb begin
    M_AXIS_TDATA  = tdata_q;
    M_AXIS_TVALID = tvalid_q;
    M_AXIS_TLAST  = last_beat;
    S_AXIS_TREADY = 1'b0;
    if (passthru) begin
      M_AXIS_TDATA  = S_AXIS_TDATA;
      M_AXIS_TVALID = S_AXIS_TVALID;
      M_AXIS_TLAST  = S_AXIS_TLAST;
      S_AXIS_TREADY = M_AXIS_TREADY;
    end else if (in_payload) begin
      M_AXIS_TDATA  = S_AXIS_TDATA;
      M_AXIS_TVALID = S_AXIS_TVALID;
      S_AXIS_TREADY = M_AXIS_TREADY;
    end
  end

  // Status word: packets sent, packet count nibble, state code.
  assign status = {sent_q, 8'h00, pkt_cnt_q, 1'b0, state_q};

endmodule

// File: tb/tb_vita49_pack.sv
// tb_vita49_pack: directed vectors for vita49_pack. Cycle tables cover the
// basic packet and backpressure; hand-written sequences cover counter wrap,
// trigger gating, soft reset, zero size and passthrough.
module tb_vita49_pack;

  logic        clk;
  logic        arstn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] ctrl;
  logic [31:0] status;
  logic [31:0] sid;
  logic [15:0] psize;
  logic        trig;
  logic [31:0] sec;
  logic [63:0] fsec;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        er;
  } vec_t;

  vec_t vecs [0:25];

  vita49_pack dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (arstn),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TREADY  (s_tready),
    .S_AXIS_TLAST   (s_tlast),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TREADY  (m_tready),
    .M_AXIS_TLAST   (m_tlast),
    .ctrl           (ctrl),
    .status         (status),
    .streamID       (sid),
    .pkt_size       (psize),
    .trig           (trig),
    .timestamp_sec  (sec),
    .timestamp_fsec (fsec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    arstn = 1'b0; ctrl = 32'd0; s_tvalid = 1'b0; s_tdata = 32'd0;
    s_tlast = 1'b0; m_tready = 1'b0; trig = 1'b0;
    @(negedge clk);
    #1;
    if (check) begin
      chk("rst_status", status, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_mdata", m_tdata, 0);
      chk("rst_sready", s_tready, 0);
      chk("rst_mlast", m_tlast, 0);
    end
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic run_rows(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      s_tvalid = vecs[i].sv; s_tdata = vecs[i].sd; m_tready = vecs[i].mr;
      #1;
      chk($sformatf("%s_valid[%0d]", tag, i), m_tvalid, vecs[i].ev);
      chk($sformatf("%s_data[%0d]", tag, i), m_tdata, vecs[i].ed);
      chk($sformatf("%s_last[%0d]", tag, i), m_tlast, vecs[i].el);
      chk($sformatf("%s_sready[%0d]", tag, i), s_tready, vecs[i].er);
      $display("row %0d %s: mvalid=%0b mdata=%h mlast=%0b sready=%0b",
               i, tag, m_tvalid, m_tdata, m_tlast, s_tready);
    end
  endtask

  initial begin
    int pkts, hdrs, last_end, bad, beats, found;
    logic [31:0] d;
    n_chk = 0; n_fail = 0;
    sid = 0; psize = 0; sec = 0; fsec = 0;

    // Basic packet rows 0..10
    vecs[0]  = '{1'b1, 32'hA0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 32'h10500009, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 32'hFACEBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 32'h7,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 32'h1,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 32'h20,       1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 32'hA0,       1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'hA1, 1'b1, 1'b1, 32'hA1,       1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'hA2, 1'b1, 1'b1, 32'hA2,       1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'hA3, 1'b1, 1'b1, 32'hA3,       1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    // Backpressure rows 11..25, downstream ready toggling every cycle
    vecs[11] = '{1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'hB0, 1'b1, 1'b1, 32'h10500007, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'hB0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 32'hB0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 32'hB0, 1'b0, 1'b1, 32'h55,       1'b0, 1'b0};
    vecs[16] = '{1'b1, 32'hB0, 1'b1, 1'b1, 32'h55,       1'b0, 1'b0};
    vecs[17] = '{1'b1, 32'hB0, 1'b0, 1'b1, 32'hAAAABBBB, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 32'hB0, 1'b1, 1'b1, 32'hAAAABBBB, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 32'hB0, 1'b0, 1'b1, 32'hCCCCDDDD, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 32'hB0, 1'b1, 1'b1, 32'hCCCCDDDD, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 32'hB0, 1'b0, 1'b1, 32'hB0,       1'b0, 1'b0};
    vecs[22] = '{1'b1, 32'hB0, 1'b1, 1'b1, 32'hB0,       1'b0, 1'b1};
    vecs[23] = '{1'b1, 32'hB1, 1'b0, 1'b1, 32'hB1,       1'b1, 1'b0};
    vecs[24] = '{1'b1, 32'hB1, 1'b1, 1'b1, 32'hB1,       1'b1, 1'b1};
    vecs[25] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0};

    // ---- basic packet
    do_reset(1'b1);
    ctrl = 32'h1; psize = 16'd4; sid = 32'hFACEBEEF; sec = 32'd7;
    fsec = 64'h0000_0001_0000_0020;
    run_rows("basic", 0, 10);
    chk("basic_sent", status[31:16], 1);
    chk("basic_cnt", status[7:4], 1);

    // ---- backpressure
    do_reset(1'b0);
    ctrl = 32'h1; psize = 16'd2; sid = 32'h12345678; sec = 32'h55;
    fsec = 64'hAAAA_BBBB_CCCC_DDDD;
    run_rows("bp", 11, 25);

    // ---- packet count wrap: 17 back-to-back packets of 2 words
    do_reset(1'b0);
    ctrl = 32'h1; psize = 16'd2;
    pkts = 0; hdrs = 0; last_end = 0; d = 32'h100;
    for (int c = 0; c < 400 && pkts < 17; c++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = d; m_tready = 1'b1;
      #1;
      if (m_tvalid && status[3:0] == 4'd2) begin
        chk($sformatf("wrap_cnt[%0d]", hdrs), m_tdata[19:16], hdrs % 16);
        if (hdrs > 0) chk($sformatf("wrap_gap[%0d]", hdrs), c - last_end, 2);
        $display("wrap hdr %0d: word=%h", hdrs, m_tdata);
        hdrs++;
      end
      if (m_tvalid && m_tready && m_tlast) begin
        pkts++;
        last_end = c;
      end
      if (s_tvalid && s_tready) d = d + 1;
    end
    chk("wrap_pkts", pkts, 17);
    @(negedge clk);
    s_tvalid = 1'b0; ctrl = 32'h0;
    @(negedge clk);
    #1;
    chk("wrap_sent", status[31:16], 17);
    chk("wrap_cnt_status", status[7:4], 1);

    // ---- trigger gate
    do_reset(1'b0);
    ctrl = 32'h9; psize = 16'd2;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = 32'hC0; m_tready = 1'b1; trig = 1'b0;
      #1;
      if (m_tvalid !== 1'b0) bad++;
    end
    chk("trig_quiet", bad, 0);
    chk("trig_armed", status[3:0], 1);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    #1;
    chk("trig_start_valid", m_tvalid, 1);
    chk("trig_start_state", status[3:0], 2);
    pkts = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (m_tvalid && m_tready && m_tlast) pkts++;
    end
    chk("trig_stream_pkts", pkts, 2);
    // enable dropped mid-packet: current packet still completes
    pkts = 0;
    @(negedge clk);
    ctrl = 32'h8;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (m_tvalid && m_tready && m_tlast) pkts++;
    end
    chk("en_drop_pkts", pkts, 1);
    chk("en_drop_state", status[3:0], 0);
    chk("en_drop_sent", status[31:16], 3);

    // ---- soft reset mid-payload
    do_reset(1'b0);
    ctrl = 32'h1; psize = 16'd4;
    pkts = 0; beats = 0; found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 32'hD0 + c;
      #1;
      if (pkts == 1 && status[3:0] == 4'd7 && beats == 2) begin
        ctrl = 32'h3;
        found = 1;
      end else begin
        if (pkts == 1 && status[3:0] == 4'd7 && m_tvalid && m_tready) beats++;
        if (m_tvalid && m_tready && m_tlast) pkts++;
      end
    end
    chk("srst_reached", found, 1);
    @(negedge clk);
    #1;
    chk("srst_mvalid", m_tvalid, 0);
    chk("srst_status", status, 0);
    chk("srst_sready", s_tready, 0);
    @(negedge clk);
    ctrl = 32'h1;
    @(negedge clk);
    #1;
    chk("srst_next_valid", m_tvalid, 1);
    chk("srst_next_cnt", m_tdata[19:16], 0);
    chk("srst_next_size", m_tdata[15:0], 9);

    // ---- zero size and input latching at packet start
    do_reset(1'b0);
    ctrl = 32'h1; psize = 16'd0; sid = 32'h11111111; sec = 32'h22;
    fsec = 64'h0000_0033_0000_0044;
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 32'hE0; m_tready = 1'b1;
    @(negedge clk);
    psize = 16'd5; sid = 32'h99999999; sec = 32'h77; fsec = 64'h0;
    #1;
    chk("zero_hdr", m_tdata, 32'h10500006);
    @(negedge clk); #1;
    chk("latch_sid", m_tdata, 32'h11111111);
    @(negedge clk); #1;
    chk("latch_sec", m_tdata, 32'h22);
    @(negedge clk); #1;
    chk("latch_tsfh", m_tdata, 32'h33);
    @(negedge clk); #1;
    chk("latch_tsfl", m_tdata, 32'h44);
    @(negedge clk); #1;
    chk("zero_pay_data", m_tdata, 32'hE0);
    chk("zero_pay_last", m_tlast, 1);
    ctrl = 32'h0;
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("zero_sent", status[31:16], 1);

    // ---- passthrough (second half also has enable set)
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ctrl = (i < 6) ? 32'h4 : 32'h5;
      s_tdata = $urandom; s_tvalid = (i % 4 != 3); s_tlast = (i % 3 == 2);
      m_tready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("pt_data[%0d]", i), m_tdata, s_tdata);
      chk($sformatf("pt_valid[%0d]", i), m_tvalid, s_tvalid);
      chk($sformatf("pt_last[%0d]", i), m_tlast, s_tlast);
      chk($sformatf("pt_sready[%0d]", i), s_tready, m_tready);
      $display("pt %0d: in=%h v=%0b l=%0b out=%h v=%0b l=%0b",
               i, s_tdata, s_tvalid, s_tlast, m_tdata, m_tvalid, m_tlast);
    end
    chk("pt_status", status, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
